// File: rtl/wb_mem_slave.sv
// Wishbone slave responder in front of a one-cycle-latency single-port SRAM.
// It decodes addresses against a base, writes byte lanes, runs incrementing bursts, and terminates bad beats with err.
module wb_mem_slave #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          MEM_BYTES  = 1 << 18,
    parameter int          DATA_WIDTH = 32,
    parameter int          BL_WIDTH   = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     wbd_adr_i,
    input  logic [DATA_WIDTH-1:0]           wbd_dat_i,
    input  logic [DATA_WIDTH/8-1:0]         wbd_sel_i,
    input  logic [BL_WIDTH-1:0]             wbd_bl_i,
    input  logic                            wbd_bry_i,
    input  logic                            wbd_we_i,
    input  logic                            wbd_cyc_i,
    input  logic                            wbd_stb_i,
    output logic [DATA_WIDTH-1:0]           wbd_dat_o,
    output logic                            wbd_ack_o,
    output logic                            wbd_lack_o,
    output logic                            wbd_err_o,
    output logic                            mem_en_o,
    output logic [DATA_WIDTH/8-1:0]         mem_we_o,
    output logic [$clog2(MEM_BYTES)-3:0]    mem_addr_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam int AW  = $clog2(MEM_BYTES) - 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        ERR
    } state_t;

    state_t                  r_state;
    logic [AW-1:0]           r_waddr;
    logic [BL_WIDTH-1:0]     r_cnt;
    logic [BL_WIDTH-1:0]     r_len;
    logic                    r_we;
    logic                    r_ack;
    logic                    r_lack;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_dat;

    logic [31:0]             w_off;
    logic                    w_first_bad;
    logic                    w_next_bad;
    logic                    w_last;
    logic [BL_WIDTH-1:0]     w_bl_len;
    logic                    w_req_go;
    logic                    w_rd_ack;

    assign w_off       = wbd_adr_i - ADDR_BASE;
    assign w_first_bad = (w_off >= 32'(MEM_BYTES)) || (wbd_adr_i[LSB-1:0] != '0);
    // Incrementing past the top word leaves the SRAM window.
    assign w_next_bad  = &r_waddr;
    assign w_last      = (r_cnt == r_len - BL_WIDTH'(1));
    assign w_bl_len    = (wbd_bl_i == '0) ? BL_WIDTH'(1) : wbd_bl_i;

    // NOTE: the SRAM strobe is combinational in REQ, so it is masked by reset
    // to guarantee no partial write lands on the edge that reset is sampled.
    assign w_req_go    = (r_state == REQ) && wbd_cyc_i && wbd_bry_i && !reset;
    assign w_rd_ack    = r_ack && !r_we;

    assign mem_en_o    = w_req_go;
    assign mem_we_o    = (w_req_go && r_we) ? wbd_sel_i : '0;
    assign mem_addr_o  = w_req_go ? r_waddr : '0;
    assign mem_wdata_o = (w_req_go && r_we) ? wbd_dat_i : '0;

    // SRAM data is only valid during the ack cycle; r_dat holds it afterwards.
    assign wbd_dat_o   = w_rd_ack ? mem_rdata_i : r_dat;
    assign wbd_ack_o   = r_ack;
    assign wbd_lack_o  = r_lack;
    assign wbd_err_o   = r_err;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_waddr <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_lack  <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack  <= 1'b0;
            r_lack <= 1'b0;
            r_err  <= 1'b0;
            if (w_rd_ack) begin
                r_dat <= mem_rdata_i;
            end

            case (r_state)
                IDLE: begin
                    if (wbd_cyc_i && wbd_stb_i) begin
                        r_waddr <= w_off[AW+LSB-1:LSB];
                        r_we    <= wbd_we_i;
                        r_len   <= w_bl_len;
                        r_cnt   <= '0;
                        if (w_first_bad) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (!wbd_cyc_i) begin
                        r_state <= IDLE;
                    end else if (wbd_bry_i) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_lack  <= w_last;
                    end
                end

                ACK: begin
                    if (w_last || !wbd_cyc_i) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + BL_WIDTH'(1);
                        r_waddr <= r_waddr + AW'(1);
                        if (w_next_bad) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= REQ;
                        end
                    end
                end

                ERR: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: a bus master task, an SRAM model,
// a reference memory and a response scoreboard.
module tb_wb_mem_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          MEMB = 1 << 18;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wbd_adr_i;
    logic [31:0] wbd_dat_i;
    logic [3:0]  wbd_sel_i;
    logic [9:0]  wbd_bl_i;
    logic        wbd_bry_i;
    logic        wbd_we_i;
    logic        wbd_cyc_i;
    logic        wbd_stb_i;
    logic [31:0] wbd_dat_o;
    logic        wbd_ack_o;
    logic        wbd_lack_o;
    logic        wbd_err_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    wb_mem_slave #(
        .ADDR_BASE (BASE),
        .MEM_BYTES (MEMB),
        .DATA_WIDTH(32),
        .BL_WIDTH  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wbd_adr_i  (wbd_adr_i),
        .wbd_dat_i  (wbd_dat_i),
        .wbd_sel_i  (wbd_sel_i),
        .wbd_bl_i   (wbd_bl_i),
        .wbd_bry_i  (wbd_bry_i),
        .wbd_we_i   (wbd_we_i),
        .wbd_cyc_i  (wbd_cyc_i),
        .wbd_stb_i  (wbd_stb_i),
        .wbd_dat_o  (wbd_dat_o),
        .wbd_ack_o  (wbd_ack_o),
        .wbd_lack_o (wbd_lack_o),
        .wbd_err_o  (wbd_err_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          is_rd;
        logic [31:0] data;
        bit          lack;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } acc_t;

    exp_t        sb_q[$];
    acc_t        mem_log[$];
    logic [31:0] sram[int];
    logic [31:0] ref_mem[int];
    logic [31:0] wbuf[0:1023];
    int          cyc_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SRAM model: one-cycle read latency, byte-lane writes.
    always @(posedge clk) begin : sram_model
        logic [31:0] w;
        if (mem_en_o === 1'b1) begin
            w = sram.exists(int'(mem_addr_o)) ? sram[int'(mem_addr_o)] : 32'h0;
            mem_rdata_i <= w;
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) w[8*b +: 8] = mem_wdata_o[8*b +: 8];
            end
            sram[int'(mem_addr_o)] = w;
        end
    end

    // Response monitor: pops the scoreboard on every ack or err.
    always @(negedge clk) begin : monitor
        exp_t e;
        acc_t a;
        if (mem_en_o === 1'b1) begin
            a.addr  = mem_addr_o;
            a.we    = mem_we_o;
            a.wdata = mem_wdata_o;
            mem_log.push_back(a);
        end
        if (reset === 1'b0 && (wbd_ack_o === 1'b1 || wbd_err_o === 1'b1)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_response", {30'b0, wbd_err_o, wbd_ack_o}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("resp_err", 32'(wbd_err_o), 32'(e.is_err));
                check("resp_ack", 32'(wbd_ack_o), 32'(!e.is_err));
                check("resp_lack", 32'(wbd_lack_o), 32'(e.lack));
                if (e.is_rd && !e.is_err) check("rd_data", wbd_dat_o, e.data);
            end
        end
    end

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input int bl, input int stall_beat, input int stall_cycles,
                           input int abort_beat);
        exp_t        e;
        logic [31:0] a, off, m;
        int          len, beats, t_last, waited, w;
        bit          done;

        len = (bl == 0) ? 1 : bl;
        for (int i = 0; i < len; i++) begin
            if (abort_beat >= 0 && i >= abort_beat) break;
            a   = adr + 32'(4 * i);
            off = a - BASE;
            e.is_err = 1'b0;
            e.is_rd  = !we;
            e.data   = 32'h0;
            e.lack   = (i == len - 1);
            if (off >= 32'(MEMB) || a[1:0] != 2'b00) begin
                e.is_err = 1'b1;
                e.lack   = 1'b0;
                sb_q.push_back(e);
                break;
            end
            w = int'(off >> 2);
            if (we) begin
                m = ref_rd(w);
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) m[8*b +: 8] = wbuf[i][8*b +: 8];
                end
                ref_mem[w] = m;
            end else begin
                e.data = ref_rd(w);
            end
            sb_q.push_back(e);
        end

        @(posedge clk); #1;
        wbd_adr_i = adr;
        wbd_we_i  = we;
        wbd_sel_i = sel;
        wbd_bl_i  = 10'(bl);
        wbd_dat_i = wbuf[0];
        wbd_bry_i = 1'b1;
        wbd_cyc_i = 1'b1;
        wbd_stb_i = 1'b1;
        t_last = cyc_cnt;
        beats  = 0;
        waited = 0;
        done   = 1'b0;

        while (!done) begin
            @(negedge clk);
            waited++;
            if (waited > 5000) begin
                check("response_timeout", 32'(waited), 32'h0);
                done = 1'b1;
            end else if (wbd_ack_o === 1'b1) begin
                if (beats == 0) check("first_ack_latency", 32'(cyc_cnt - t_last), 32'd2);
                else check("beat_spacing", 32'(cyc_cnt - t_last),
                           (beats == stall_beat) ? 32'(2 + stall_cycles) : 32'd2);
                t_last = cyc_cnt;
                beats++;
                waited = 0;
                if (wbd_lack_o === 1'b1) begin
                    done = 1'b1;
                end else if (beats < len) begin
                    wbd_dat_i = wbuf[beats];
                    if (beats == abort_beat) begin
                        @(posedge clk); #1;
                        wbd_cyc_i = 1'b0;
                        wbd_stb_i = 1'b0;
                        repeat (4) begin
                            @(negedge clk);
                            check("abort_quiet", {30'b0, wbd_ack_o, mem_en_o}, 32'h0);
                        end
                        return;
                    end
                    if (beats == stall_beat) begin
                        wbd_bry_i = 1'b0;
                        repeat (stall_cycles) begin
                            @(negedge clk);
                            check("stall_mem_en", 32'(mem_en_o), 32'h0);
                        end
                        @(posedge clk); #1;
                        wbd_bry_i = 1'b1;
                    end
                end
            end else if (wbd_err_o === 1'b1) begin
                done = 1'b1;
            end
        end

        @(posedge clk); #1;
        wbd_cyc_i = 1'b0;
        wbd_stb_i = 1'b0;
        wbd_we_i  = 1'b0;
        wbd_sel_i = 4'h0;
        @(negedge clk);
        check("idle_after", {28'b0, wbd_ack_o, wbd_lack_o, wbd_err_o, mem_en_o}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        wbd_adr_i = '0;
        wbd_dat_i = '0;
        wbd_sel_i = '0;
        wbd_bl_i  = '0;
        wbd_bry_i = 1'b1;
        wbd_we_i  = 1'b0;
        wbd_cyc_i = 1'b0;
        wbd_stb_i = 1'b0;
        for (int i = 0; i < 1024; i++) wbuf[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {24'b0, wbd_ack_o, wbd_lack_o, wbd_err_o, mem_en_o, mem_we_o}, 32'h0);
        check("reset_dat_o", wbd_dat_o, 32'h0);
        check("reset_mem_addr", 32'(mem_addr_o), 32'h0);
        check("reset_mem_wdata", mem_wdata_o, 32'h0);
        mem_log.delete();

        // Single write then read back.
        wbuf[0] = 32'h1;
        wb_xfer(32'h8000_1000, 1'b1, 4'hF, 1, -1, 0, -1);
        check("t1_mem_accesses", 32'(mem_log.size()), 32'd1);
        if (mem_log.size() > 0) begin
            check("t1_mem_addr", 32'(mem_log[0].addr), 32'h0400);
            check("t1_mem_we", 32'(mem_log[0].we), 32'hF);
            check("t1_mem_wdata", mem_log[0].wdata, 32'h1);
        end
        wb_xfer(32'h8000_1000, 1'b0, 4'hF, 1, -1, 0, -1);

        // Byte-lane write into a zeroed word.
        wbuf[0] = 32'h0;
        wb_xfer(32'h8000_0020, 1'b1, 4'hF, 1, -1, 0, -1);
        wbuf[0] = 32'hAABB_CCDD;
        mem_log.delete();
        wb_xfer(32'h8000_0020, 1'b1, 4'b0010, 1, -1, 0, -1);
        if (mem_log.size() > 0) check("t2_mem_we", 32'(mem_log[0].we), 32'h2);
        else check("t2_mem_accesses", 32'(mem_log.size()), 32'd1);
        wb_xfer(32'h8000_0020, 1'b0, 4'hF, 1, -1, 0, -1);
        check("t2_byte_readback", wbd_dat_o, 32'h0000_CC00);

        // Read burst of four over words 1,2,3,4.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        wb_xfer(32'h8000_0010, 1'b1, 4'hF, 4, -1, 0, -1);
        mem_log.delete();
        wb_xfer(32'h8000_0010, 1'b0, 4'hF, 4, -1, 0, -1);
        check("t3_mem_accesses", 32'(mem_log.size()), 32'd4);
        for (int i = 0; i < mem_log.size() && i < 4; i++) begin
            check("t3_mem_addr", 32'(mem_log[i].addr), 32'(4 + i));
            check("t3_mem_we", 32'(mem_log[i].we), 32'h0);
        end
        check("t3_dat_hold", wbd_dat_o, 32'h4);

        // Write burst with bry low for three cycles before the second beat.
        wbuf[0] = 32'h1111_1111;
        wbuf[1] = 32'h2222_2222;
        wb_xfer(32'h8000_0100, 1'b1, 4'hF, 2, 1, 3, -1);
        wb_xfer(32'h8000_0100, 1'b0, 4'hF, 2, -1, 0, -1);

        // Error terminations.
        mem_log.delete();
        wb_xfer(32'h7FFF_FFFC, 1'b0, 4'hF, 1, -1, 0, -1);
        check("t5_below_base_no_mem", 32'(mem_log.size()), 32'h0);
        wb_xfer(32'h8000_0002, 1'b1, 4'hF, 1, -1, 0, -1);
        check("t5_misaligned_no_mem", 32'(mem_log.size()), 32'h0);
        wb_xfer(32'h8003_FFFC, 1'b0, 4'hF, 2, -1, 0, -1);
        check("t5_edge_one_access", 32'(mem_log.size()), 32'd1);

        // Abort a read burst by dropping cyc in REQ after the first beat.
        wb_xfer(32'h8000_0010, 1'b0, 4'hF, 4, -1, 0, 1);

        // Reset during a stalled write REQ.
        mem_log.delete();
        @(posedge clk); #1;
        wbd_adr_i = 32'h8000_0040;
        wbd_we_i  = 1'b1;
        wbd_sel_i = 4'hF;
        wbd_bl_i  = 10'd1;
        wbd_dat_i = 32'hDEAD_BEEF;
        wbd_bry_i = 1'b0;
        wbd_cyc_i = 1'b1;
        wbd_stb_i = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b1;
        wbd_bry_i = 1'b1;
        @(negedge clk);
        check("rst_no_mem_we", 32'(mem_we_o), 32'h0);
        @(posedge clk); #1;
        reset     = 1'b0;
        wbd_cyc_i = 1'b0;
        wbd_stb_i = 1'b0;
        wbd_we_i  = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {24'b0, wbd_ack_o, wbd_lack_o, wbd_err_o, mem_en_o, mem_we_o}, 32'h0);
        check("rst_dat_o", wbd_dat_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_no_mem_access", 32'(mem_log.size()), 32'h0);
        wb_xfer(32'h8000_0040, 1'b0, 4'hF, 1, -1, 0, -1);

        // Write with no lanes enabled leaves the word untouched.
        wbuf[0] = 32'hFFFF_FFFF;
        mem_log.delete();
        wb_xfer(32'h8000_0010, 1'b1, 4'h0, 1, -1, 0, -1);
        if (mem_log.size() > 0) check("sel0_mem_we", 32'(mem_log[0].we), 32'h0);
        else check("sel0_mem_accesses", 32'(mem_log.size()), 32'd1);
        wb_xfer(32'h8000_0010, 1'b0, 4'hF, 1, -1, 0, -1);

        // bl=0 behaves as a single beat.
        wb_xfer(32'h8000_0014, 1'b0, 4'hF, 0, -1, 0, -1);
        check("bl0_data", wbd_dat_o, 32'h2);

        // Maximum-length burst, written then read back.
        for (int i = 0; i < 1024; i++) wbuf[i] = 32'(i * 3 + 7);
        wb_xfer(32'h8000_2000, 1'b1, 4'hF, 1023, -1, 0, -1);
        wb_xfer(32'h8000_2000, 1'b0, 4'hF, 1023, -1, 0, -1);
        check("max_burst_last_data", wbd_dat_o, 32'(1022 * 3 + 7));

        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
Wishbone slave responder that fronts a synchronous single-port SRAM (one-cycle read latency) for the core's I$/D$ masters behind wb_interconnect. It replaces the ad-hoc ack register with a proper responder providing:
- address decode against a base address, with range and alignment checking;
- byte-lane writes;
- incrementing bursts with bl/bry/lack;
- error termination.

Parameters:
ADDR_BASE, 32'h8000_0000, byte address mapped to SRAM offset 0
MEM_BYTES, 1<<18, SRAM size in bytes (power of two)
DATA_WIDTH, 32, bus/SRAM word width
BL_WIDTH, 10, burst-length field width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wbd_adr_i  in  32  byte address
wbd_dat_i  in  32  write data
wbd_sel_i  in  4  byte lane enables
wbd_bl_i  in  10  burst length in beats, 0 treated as 1
wbd_bry_i  in  1  master beat-ready
wbd_we_i  in  1  1=write
wbd_cyc_i  in  1  cycle valid
wbd_stb_i  in  1  strobe
wbd_dat_o  out  32  read data
wbd_ack_o  out  1  beat acknowledge
wbd_lack_o  out  1  last-beat acknowledge
wbd_err_o  out  1  error termination
mem_en_o  out  1  SRAM access enable
mem_we_o  out  4  SRAM byte write enables
mem_addr_o  out  16  SRAM word address (log2(MEM_BYTES)-2 bits)
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid cycle after mem_en_o

Behaviour:
- Reset: state=IDLE; all outputs 0, including wbd_dat_o; beat counter and address register = 0.
- Offset: off = wbd_adr_i - ADDR_BASE. A beat is bad if off >= MEM_BYTES or addr[1:0] != 0.
- IDLE:
  - On cyc&stb, latch off[.. :2], we, and len = (bl==0 ? 1 : bl).
  - If the first beat is bad -> ERR; otherwise -> REQ.
- REQ:
  - If cyc=0 -> IDLE (abort, no ack, no memory access).
  - If bry=0 -> stay in REQ, mem_en_o=0 (stall).
  - Else drive mem_en_o=1 and mem_addr_o = latched word address.
  - On writes, also drive mem_we_o = sel & {4{we}} and mem_wdata_o = wbd_dat_i, all in this cycle; -> ACK.
- ACK:
  - wbd_ack_o=1 for exactly one cycle.
  - Reads: wbd_dat_o = mem_rdata_i, registered and held until the next read ack.
  - On the last beat (count == len-1), also assert wbd_lack_o=1 -> IDLE.
  - Otherwise increment count and word address.
    - If the next address is bad -> ERR.
    - Else -> REQ.
- ERR:
  - wbd_err_o=1 for one cycle; no ack, no lack, no memory access.
  - Remaining burst discarded -> IDLE.
- Latency and throughput: 2 cycles per beat (REQ, ACK) when bry=1. A single read or write is acked on the 2nd cycle after cyc&stb is first sampled in IDLE.
- sel=0 on a write: acked normally, mem_we_o=0.
- cyc dropped during ACK: the ack still pulses, then -> IDLE.
- Counter width: BL_WIDTH. A maximum burst of 1023 beats completes without wrap.
- Reset asserted in any state: -> IDLE next edge, outputs cleared, no partial write after reset.

Test Plan:
1. Single write: adr=32'h8000_1000, dat=1, sel=4'hF -> mem_we_o=4'hF, mem_addr_o=16'h0400 one cycle; ack (no err) two cycles after strobe; a single read of the same address returns 32'h1 with lack=1.
2. Byte write: sel=4'b0010, dat=32'hAABBCCDD to a word holding 0 -> mem_we_o=4'b0010; readback = 32'h0000CC00.
3. Read burst: bl=4 from 32'h8000_0010 over preloaded words 1,2,3,4 -> four acks every 2 cycles with data 1,2,3,4; lack only on the 4th; mem_addr_o 4,5,6,7.
4. bry stall: write burst bl=2 with bry held low 3 cycles before the 2nd beat -> mem_en_o low during the stall; exactly 2 acks; lack on the 2nd; data correct.
5. Errors:
   - adr=32'h7FFF_FFFC -> err=1 one cycle, no ack.
   - adr=32'h8000_0002 -> err.
   - bl=2 at 32'h8003_FFFC -> first beat ack, second beat err, no lack.
6. Abort/reset: cyc dropped in REQ mid-burst -> no further acks, IDLE. Reset asserted during a write REQ -> no mem_we_o pulse afterwards; all outputs 0.
